// File: rtl/fifo_buffer_param.sv
// Parametrised synchronous FIFO with full-range word count, programmable
// almost-full/empty thresholds, optional first-word-fall-through and sticky error flags.
module fifo_buffer_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic [ADDR_WIDTH:0]   al_full_th,
  input  logic [ADDR_WIDTH:0]   al_empty_th,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  al_full,
  output logic                  al_empty,
  output logic [ADDR_WIDTH:0]   wd_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  rd_acc;
  logic                  wr_acc;

  assign full     = (cnt == FULL_CNT);
  assign empty    = (cnt == '0);
  assign wd_cnt   = cnt;
  assign al_full  = (cnt >= al_full_th);
  assign al_empty = (cnt <= al_empty_th);

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
      // A fresh error outranks a simultaneous clear.
      if (wr && !wr_acc)      overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rd && !rd_acc)      underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

  // NOTE: storage has no reset; pointers and count define what is valid, and
  // leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= wr_data;
  end

  if (FWFT) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_std
    // At full with read and write on the same slot, the old word is returned.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end

endmodule
